sw_duty_ramp: RTL and testbench

Upstream control stage for the LED PWM path. It synchronises and debounces the board switches and maps the stable code to an 8-bit target duty. It then slews the output duty toward that target one LSB per ramp tick, so brightness fades instead of jumping. The output `o_duty` feeds the PWM generator's duty input directly; `o_duty_upd` marks every change.

---
 rtl/led_pwm_pkg.sv | 16 +
 rtl/sw_debounce.sv | 48 ++++
 rtl/sw_duty_ramp.sv | 91 +++++++++
 tb/tb_sw_duty_ramp.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_pwm_pkg.sv
// Shared types and default timing constants for the LED PWM control path.
package led_pwm_pkg;

  typedef logic [7:0] duty_t;

  typedef enum logic [1:0] {
    IDLE,
    RAMP_UP,
    RAMP_DOWN
  } ramp_state_e;

  // 10 ms debounce and 1 ms per duty step at a 50 MHz board clock.
  localparam int DEB_CYCLES_DEF = 500000;
  localparam int RAMP_DIV_DEF   = 50000;

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus an independent debounce counter per switch bit.
// A bit is accepted only after its synced level differs from the stable level for CYCLES samples.
module sw_debounce
  import led_pwm_pkg::*;
#(
  parameter int W      = 4,
  parameter int CYCLES = DEB_CYCLES_DEF
) (
  input  logic         i_board_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_sw,
  output logic [W-1:0] o_sw_stable
);

  localparam int             CW      = (CYCLES > 2) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES - 1);

  logic [W-1:0]  sync_q1;
  logic [W-1:0]  sync_q2;
  logic [CW-1:0] cnt_q [W];

  always_ff @(posedge i_board_clk) begin
    if (i_rst) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
      // so the synchroniser really is two stages deep regardless of statement order.
      sync_q1     <= '0;
      sync_q2     <= '0;
      o_sw_stable <= '0;
      // NOTE: the counter array is small and must restart from zero after reset,
      // so it is cleared explicitly rather than left to power-up contents.
      for (int i = 0; i < W; i++) cnt_q[i] <= '0;
    end else begin
      sync_q1 <= i_sw;
      sync_q2 <= sync_q1;
      for (int i = 0; i < W; i++) begin
        if (sync_q2[i] == o_sw_stable[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          o_sw_stable[i] <= sync_q2[i];
          cnt_q[i]       <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + {{(CW-1){1'b0}}, 1'b1};
        end
      end
    end
  end

endmodule

// File: rtl/sw_duty_ramp.sv
// Debounced switch code -> replicated target duty -> ramped PWM duty, one LSB per ramp tick.
// DUTY_W must be an integer multiple of SW_W so the switch code tiles the duty word exactly.
module sw_duty_ramp
  import led_pwm_pkg::*;
#(
  parameter int SW_W       = 4,
  parameter int DUTY_W     = 8,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int RAMP_DIV   = RAMP_DIV_DEF
) (
  input  logic              i_board_clk,
  input  logic              i_rst,
  input  logic [SW_W-1:0]   i_sw,
  output logic [SW_W-1:0]   o_sw_stable,
  output logic [DUTY_W-1:0] o_target,
  output logic [DUTY_W-1:0] o_duty,
  output logic              o_duty_upd,
  output logic              o_busy
);

  localparam int             TW       = (RAMP_DIV > 2) ? $clog2(RAMP_DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(RAMP_DIV - 1);

  ramp_state_e       state_q;
  logic [TW-1:0]     tick_q;
  logic [DUTY_W-1:0] duty_up;
  logic [DUTY_W-1:0] duty_dn;

  sw_debounce #(
    .W      (SW_W),
    .CYCLES (DEB_CYCLES)
  ) u_debounce (
    .i_board_clk (i_board_clk),
    .i_rst       (i_rst),
    .i_sw        (i_sw),
    .o_sw_stable (o_sw_stable)
  );

  // Steps are only taken toward the target, so these never wrap in use.
  assign duty_up = o_duty + {{(DUTY_W-1){1'b0}}, 1'b1};
  assign duty_dn = o_duty - {{(DUTY_W-1){1'b0}}, 1'b1};
  assign o_busy  = (state_q != IDLE);

  always_ff @(posedge i_board_clk) begin
    if (i_rst) begin
      o_target <= '0;
    end else begin
      o_target <= {(DUTY_W/SW_W){o_sw_stable}};
    end
  end

  // Direction is re-decided at every terminal tick, so a target change mid-ramp
  // reverses at the next tick without losing the partial tick count.
  always_ff @(posedge i_board_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      o_duty     <= '0;
      o_duty_upd <= 1'b0;
    end else begin
      o_duty_upd <= 1'b0;
      case (state_q)
        IDLE: begin
          tick_q <= '0;
          if (o_target > o_duty)      state_q <= RAMP_UP;
          else if (o_target < o_duty) state_q <= RAMP_DOWN;
        end
        RAMP_UP, RAMP_DOWN: begin
          if (tick_q == TICK_MAX) begin
            tick_q <= '0;
            if (o_target > o_duty) begin
              o_duty     <= duty_up;
              o_duty_upd <= 1'b1;
              state_q    <= (duty_up == o_target) ? IDLE : RAMP_UP;
            end else if (o_target < o_duty) begin
              o_duty     <= duty_dn;
              o_duty_upd <= 1'b1;
              state_q    <= (duty_dn == o_target) ? IDLE : RAMP_DOWN;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            tick_q <= tick_q + {{(TW-1){1'b0}}, 1'b1};
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sw_duty_ramp.sv
// Bench for sw_duty_ramp: a cycle model built from the behavioural rules checks every output
// every cycle, while directed scenarios pin the model with hand-computed values.
module tb_sw_duty_ramp;

  localparam int SW_W   = 4;
  localparam int DUTY_W = 8;
  localparam int DEB    = 4;
  localparam int RDIV   = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [SW_W-1:0]   sw  = 4'hA;
  logic [SW_W-1:0]   o_sw_stable;
  logic [DUTY_W-1:0] o_target;
  logic [DUTY_W-1:0] o_duty;
  logic              o_duty_upd;
  logic              o_busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sw_duty_ramp #(
    .SW_W       (SW_W),
    .DUTY_W     (DUTY_W),
    .DEB_CYCLES (DEB),
    .RAMP_DIV   (RDIV)
  ) dut (
    .i_board_clk (clk),
    .i_rst       (rst),
    .i_sw        (sw),
    .o_sw_stable (o_sw_stable),
    .o_target    (o_target),
    .o_duty      (o_duty),
    .o_duty_upd  (o_duty_upd),
    .o_busy      (o_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: a switch bit is accepted after DEB consecutive differing synced samples,
  // the target is the stable code times 0x11, and while ramping one step lands every RDIV cycles.
  logic [SW_W-1:0]   m_s1 = '0, m_s2 = '0, m_stable = '0;
  logic [DUTY_W-1:0] m_target = '0, m_duty = '0;
  logic              m_busy = 1'b0, m_upd = 1'b0;
  int                m_cd = 0;
  logic [SW_W-1:0]   m_hist[$];

  initial begin
    logic [SW_W-1:0] sw_s;
    logic            rst_s;
    bit              all_diff;
    forever begin
      @(posedge clk);
      sw_s  = sw;
      rst_s = rst;
      if (rst_s) begin
        m_s1 = '0; m_s2 = '0; m_stable = '0; m_target = '0; m_duty = '0;
        m_busy = 1'b0; m_upd = 1'b0; m_cd = 0;
        m_hist.delete();
      end else begin
        m_upd = 1'b0;
        if (!m_busy) begin
          if (m_target != m_duty) begin
            m_busy = 1'b1;
            m_cd   = RDIV;
          end
        end else begin
          m_cd = m_cd - 1;
          if (m_cd == 0) begin
            m_cd = RDIV;
            if (m_target > m_duty) begin
              m_duty = m_duty + 8'd1; m_upd = 1'b1;
            end else if (m_target < m_duty) begin
              m_duty = m_duty - 8'd1; m_upd = 1'b1;
            end
            if (m_duty == m_target) m_busy = 1'b0;
          end
        end
        m_target = 8'(m_stable * 17);
        m_hist.push_back(m_s2);
        if (m_hist.size() > DEB) void'(m_hist.pop_front());
        for (int b = 0; b < SW_W; b++) begin
          all_diff = (m_hist.size() == DEB);
          foreach (m_hist[k]) if (m_hist[k][b] == m_stable[b]) all_diff = 1'b0;
          if (all_diff) m_stable[b] = ~m_stable[b];
        end
        m_s2 = m_s1;
        m_s1 = sw_s;
      end
      #1;
      check("model_sw_stable", 32'(o_sw_stable), 32'(m_stable));
      check("model_target",    32'(o_target),    32'(m_target));
      check("model_duty",      32'(o_duty),      32'(m_duty));
      check("model_duty_upd",  32'(o_duty_upd),  32'(m_upd));
      check("model_busy",      32'(o_busy),      32'(m_busy));
    end
  end

  task automatic wait_duty(input logic [7:0] val, input bit need_idle, input int max,
                           input string name);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (o_duty == val && (!need_idle || !o_busy)) break;
    end
    check(name, 32'(o_duty), 32'(val));
    if (need_idle) check({name, "_idle"}, 32'(o_busy), 32'd0);
  endtask

  task automatic hold_steady(input logic [7:0] val, input int n, input string name);
    int moved = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (o_duty_upd || o_duty != val) moved++;
    end
    check(name, 32'(moved), 32'd0);
  endtask

  initial begin
    int pulses, bad_gap, bad_inc, last, bad_bounce, min_duty, max_duty;
    logic [7:0] prev;

    // Reset then idle
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_outputs", 32'({o_sw_stable, o_target, o_duty, o_duty_upd, o_busy}), 32'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (o_sw_stable == 4'hA) break;
    end
    check("stable_after_rst", 32'(o_sw_stable), 32'hA);
    @(negedge clk);
    check("target_aa", 32'(o_target), 32'hAA);

    // Ramp up 0 -> 170
    pulses = 0; bad_gap = 0; bad_inc = 0; last = -1; prev = 8'd0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (o_duty_upd) begin
        pulses++;
        if (last >= 0 && i - last != RDIV) bad_gap++;
        if (o_duty != prev + 8'd1) bad_inc++;
        prev = o_duty;
        last = i;
      end
      if (o_duty == 8'd170 && !o_busy) break;
    end
    check("ramp_pulses", 32'(pulses), 32'd170);
    check("ramp_gaps", 32'(bad_gap), 32'd0);
    check("ramp_incr", 32'(bad_inc), 32'd0);
    check("ramp_final", 32'(o_duty), 32'd170);
    check("ramp_idle", 32'(o_busy), 32'd0);

    // Bounce reject on bit 0
    bad_bounce = 0;
    for (int k = 0; k < 20; k++) begin
      sw[0] = ~sw[0];
      repeat (2) begin
        @(negedge clk);
        if (o_sw_stable != 4'hA || o_duty_upd) bad_bounce++;
      end
    end
    sw = 4'hA;
    repeat (10) begin
      @(negedge clk);
      if (o_sw_stable != 4'hA || o_duty_upd) bad_bounce++;
    end
    check("bounce_reject", 32'(bad_bounce), 32'd0);

    // Down to 0, then reversal mid-ramp toward 0x11
    sw = 4'h0;
    wait_duty(8'h00, 1'b1, 600, "down_to_zero");
    sw = 4'hF;
    wait_duty(8'h20, 1'b0, 200, "reach_20");
    sw = 4'h1;
    min_duty = 255; max_duty = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (o_duty < min_duty) min_duty = o_duty;
      if (o_duty > max_duty) max_duty = o_duty;
      if (o_duty == 8'h11 && !o_busy) break;
    end
    check("rev_final", 32'(o_duty), 32'h11);
    check("rev_no_overshoot", 32'(min_duty), 32'h11);
    check("rev_kept_rising", 32'(max_duty > 8'h20), 32'd1);
    hold_steady(8'h11, 12, "rev_hold");

    // Reset mid-ramp toward 0x44
    sw = 4'h4;
    wait_duty(8'h40, 1'b0, 300, "reach_40");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_duty", 32'(o_duty), 32'd0);
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_target", 32'(o_target), 32'd0);
    check("midrst_stable", 32'(o_sw_stable), 32'd0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (o_duty_upd) break;
    end
    check("midrst_first_step", 32'(o_duty), 32'd1);
    wait_duty(8'h44, 1'b1, 300, "midrst_final");

    // Extremes
    sw = 4'hF;
    wait_duty(8'hFF, 1'b1, 700, "top_ff");
    hold_steady(8'hFF, 20, "top_no_wrap");
    sw = 4'h0;
    wait_duty(8'h00, 1'b1, 700, "bottom_00");
    hold_steady(8'h00, 20, "bottom_no_underflow");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
